// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage with a prefetch FIFO between a latency-tolerant
//   instruction-memory port and the ID pipeline register.  PC generation
//   runs ahead of ID and is limited only by FIFO space, so the FIFO can never
//   overflow.  Redirects (jump/branch/return) flush the FIFO and silently drop
//   responses that are still in flight.  Kill squashes the output register.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   stall                 ID not accepting; output register and FIFO pops freeze
//   kill                  squash the instruction currently in the output register
//   pc_src                00 sequential, 01 j_imm, 10 i_imm, 11 ret_addr
//   j_imm/i_imm/ret_addr  redirect targets
//   imem_req/imem_addr    fetch request / address (issue on req & gnt)
//   imem_gnt              request accepted
//   imem_rvalid/rdata     in-order response, at least one cycle after issue
//   out_valid/instr/npc   {instr, address+1} to ID; NOP_INSTR when !out_valid
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters
//   perf_stall_cyc (cycles with stall=1) and perf_redirects (redirect edges).
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int                 INSTR_W    = 16,
    parameter int                 ADDR_W     = 16,
    parameter int                 FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               kill,
    input  logic [1:0]         pc_src,
    input  logic [ADDR_W-1:0]  j_imm,
    input  logic [ADDR_W-1:0]  i_imm,
    input  logic [ADDR_W-1:0]  ret_addr,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]        perf_stall_cyc,
    output logic [31:0]        perf_redirects,
`endif
    output logic [ADDR_W-1:0]  out_npc
);

    localparam int              PW      = $clog2(FIFO_DEPTH);
    localparam int              CW      = PW + 1;
    localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  resp_pc;
    logic [INSTR_W-1:0] fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0]  fifo_npc   [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      drop;

    logic               redirect;
    logic [ADDR_W-1:0]  target;
    logic [CW:0]        occupancy;
    logic               issue;
    logic               discard;
    logic               push;
    logic               pop;

    assign redirect = (pc_src != 2'b00);

    always_comb begin
        target = pc;
        case (pc_src)
            2'b01:   target = j_imm;
            2'b10:   target = i_imm;
            2'b11:   target = ret_addr;
            default: target = pc;
        endcase
    end

    // In-flight requests reserve FIFO space so a late response always fits.
    // rst_n gates the request so it is low while reset is held.
    assign occupancy = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = rst_n & ~redirect & (occupancy < {1'b0, DEPTH_C});
    assign imem_addr = pc;
    assign issue     = imem_req & imem_gnt;

    assign discard = imem_rvalid & (drop != '0);
    assign push    = imem_rvalid & (drop == '0) & ~redirect;
    assign pop     = ~redirect & ~kill & ~stall & (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= imem_rdata;
            fifo_npc[wr_ptr]   <= resp_pc + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            out_valid   <= 1'b0;
            out_instr   <= NOP_INSTR;
            out_npc     <= RESET_PC;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid);

            if (redirect) begin
                // Every request still in flight after this edge belongs to the
                // old path; a response arriving on this edge is lost with the flush.
                pc      <= target;
                resp_pc <= target;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                drop    <= outstanding - CW'(imem_rvalid);
            end else begin
                if (issue)   pc      <= pc + ADDR_W'(1);
                if (discard) drop    <= drop - CW'(1);
                if (push) begin
                    resp_pc <= resp_pc + ADDR_W'(1);
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop)     rd_ptr  <= rd_ptr + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end

            if (redirect || kill) begin
                out_valid <= 1'b0;
                out_instr <= NOP_INSTR;
            end else if (!stall) begin
                if (count != '0) begin
                    out_valid <= 1'b1;
                    out_instr <= fifo_instr[rd_ptr];
                    out_npc   <= fifo_npc[rd_ptr];
                end else begin
                    out_valid <= 1'b0;
                    out_instr <= NOP_INSTR;
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cyc <= '0;
            perf_redirects <= '0;
        end else begin
            if (stall && (perf_stall_cyc != '1))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (redirect && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule
